// File: rtl/mips_timer_slave.sv
// mips_timer_slave
// ----------------
// Memory-mapped timer that responds on the single-cycle MIPS data bus.
// It has a prescaled 32-bit up-counter, a compare match that either
// auto-reloads or stops the timer (one-shot), a sticky write-1-to-clear
// match flag, and an optional registered interrupt request.
// Reads are combinational so the CPU gets data in the same cycle.
// Writes commit on the rising clock edge.
//
// Register window (byte offsets from BASE_ADDR):
//   0x00 CTRL   bit0 EN, bit1 AR (auto-reload), bit2 IE
//   0x04 PRESC  [PRESC_W-1:0]
//   0x08 COUNT  [31:0]
//   0x0C CMP    [31:0]
//   0x10 STATUS bit0 MF, write 1 to clear
//   0x14-0x1C   reserved, read 0, writes ignored
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   memwrite     CPU store strobe
//   memaddr      CPU byte address (bits [1:0] ignored)
//   memwritedata CPU store data
//   memreaddata  combinational read data (0 when hit=0)
//   hit          combinational window decode of memaddr
//   irq          registered interrupt request (MF & IE)
//
// Build option: define MIPS_TIMER_IRQ_EN to include CTRL.IE and the irq
// flop. Without it irq is tied low and CTRL bit2 reads 0.

module mips_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_PRESC  = 3'd1;
    localparam logic [2:0] IDX_COUNT  = 3'd2;
    localparam logic [2:0] IDX_CMP    = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;

    localparam logic [PRESC_W-1:0] PCNT_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PCNT_ONE  = PRESC_W'(1'b1);

    logic               en_q, en_d;
    logic               ar_q, ar_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q, cmp_d;
    logic               mf_q, mf_d;

    logic               wr_s;
    logic [2:0]         idx_s;
    logic               tick_s;
    logic               match_s;
    logic               pcnt_clr_s;
    logic               mf_clr_s;
    logic               ie_rd_s;
    logic [31:0]        presc_ext_s;
    logic               unused_s;

    // Address bits [1:0] are intentionally ignored (word registers only).
    assign unused_s = ^memaddr[1:0];

    assign hit     = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign wr_s    = memwrite & hit;
    assign idx_s   = memaddr[4:2];
    assign tick_s  = en_q & (pcnt_q == presc_q);
    assign match_s = tick_s & (count_q == cmp_q);

    // Prescale counter restarts on a PRESC write or a CTRL write that disables.
    assign pcnt_clr_s = wr_s & ((idx_s == IDX_PRESC) |
                                ((idx_s == IDX_CTRL) & ~memwritedata[0]));
    assign mf_clr_s   = wr_s & (idx_s == IDX_STATUS) & memwritedata[0];

`ifdef MIPS_TIMER_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    assign irq_d   = mf_q & ie_q;
    assign irq     = irq_q;
    assign ie_rd_s = ie_q;

    // IE bit: only a CTRL write changes it.
    always_comb begin
        ie_d = ie_q;
        if (wr_s && (idx_s == IDX_CTRL)) begin
            ie_d = memwritedata[2];
        end else begin
            ie_d = ie_q;
        end
    end

    // Interrupt-enable and interrupt-request flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
`else
    assign irq     = 1'b0;
    assign ie_rd_s = 1'b0;
`endif

    // Next-state for timer registers: tick rules first, CPU writes override.
    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        mf_d    = mf_q;

        if (pcnt_clr_s || !en_q || tick_s) begin
            pcnt_d = PCNT_ZERO;
        end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end

        // A CPU write to COUNT drops any tick update in the same cycle.
        if (wr_s && (idx_s == IDX_COUNT)) begin
            count_d = memwritedata;
        end else if (match_s) begin
            if (ar_q) begin
                count_d = 32'h0000_0000;
            end else begin
                count_d = count_q;
            end
        end else if (tick_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        // A CTRL write wins over the one-shot auto-disable.
        if (wr_s && (idx_s == IDX_CTRL)) begin
            en_d = memwritedata[0];
            ar_d = memwritedata[1];
        end else if (match_s && !ar_q) begin
            en_d = 1'b0;
            ar_d = ar_q;
        end else begin
            en_d = en_q;
            ar_d = ar_q;
        end

        if (wr_s && (idx_s == IDX_PRESC)) begin
            presc_d = memwritedata[PRESC_W-1:0];
        end else begin
            presc_d = presc_q;
        end

        if (wr_s && (idx_s == IDX_CMP)) begin
            cmp_d = memwritedata;
        end else begin
            cmp_d = cmp_q;
        end

        // A new match beats a simultaneous clear.
        if (match_s) begin
            mf_d = 1'b1;
        end else if (mf_clr_s) begin
            mf_d = 1'b0;
        end else begin
            mf_d = mf_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            presc_q <= PCNT_ZERO;
            pcnt_q  <= PCNT_ZERO;
            count_q <= 32'h0000_0000;
            cmp_q   <= 32'h0000_0000;
            mf_q    <= 1'b0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            mf_q    <= mf_d;
        end
    end

    // Zero-extend the prescaler for the 32-bit read path.
    always_comb begin
        presc_ext_s                = 32'h0000_0000;
        presc_ext_s[PRESC_W-1:0]   = presc_q;
    end

    // Combinational read mux; outside the window the bus sees zero.
    always_comb begin
        memreaddata = 32'h0000_0000;
        if (hit) begin
            case (idx_s)
                IDX_CTRL:   memreaddata = {29'h0, ie_rd_s, ar_q, en_q};
                IDX_PRESC:  memreaddata = presc_ext_s;
                IDX_COUNT:  memreaddata = count_q;
                IDX_CMP:    memreaddata = cmp_q;
                IDX_STATUS: memreaddata = {31'h0, mf_q};
                default:    memreaddata = 32'h0000_0000;
            endcase
        end else begin
            memreaddata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mips_timer_slave.sv
module tb_mips_timer_slave;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef MIPS_TIMER_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        hit;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (what a programmer sees through the registers).
    logic        m_en, m_ar, m_ie, m_mf, m_irq;
    logic [15:0] m_presc, m_pcnt;
    logic [31:0] m_count, m_cmp;

    mips_timer_slave #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .hit          (hit),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_ar = 1'b0; m_ie = 1'b0; m_mf = 1'b0; m_irq = 1'b0;
        m_presc = 16'h0; m_pcnt = 16'h0; m_count = 32'h0; m_cmp = 32'h0;
    endtask

    // One clock of the timer as the programmer's guide describes it.
    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic        in_win, tick, match;
        off    = a - BASE;
        in_win = (off < 32'd32);
        off    = off & 32'hFFFF_FFFC;
        tick   = m_en && (m_pcnt == m_presc);
        match  = tick && (m_count == m_cmp);
        m_irq  = m_mf && m_ie;
        m_pcnt = (m_en && !tick) ? m_pcnt + 16'd1 : 16'd0;
        if (match) begin
            m_mf = 1'b1;
            if (m_ar) m_count = 32'd0;
            else      m_en = 1'b0;
        end else if (tick) begin
            m_count = m_count + 32'd1;
        end
        if (we && in_win) begin
            case (off)
                32'd0: begin
                    m_en = d[0];
                    m_ar = d[1];
                    if (HAS_IRQ) m_ie = d[2];
                    if (!d[0]) m_pcnt = 16'd0;
                end
                32'd4:  begin m_presc = d[15:0]; m_pcnt = 16'd0; end
                32'd8:  m_count = d;
                32'd12: m_cmp = d;
                32'd16: if (d[0] && !match) m_mf = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic bus_cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite = we; memaddr = a; memwritedata = d;
        model_step(we, a, d);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        bus_cycle(1'b1, BASE + off, d);
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
        memwrite = 1'b0;
        memaddr  = BASE + off;
        #1;
        chk(tag, memreaddata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        memwrite = 1'b0;
        model_reset();
        chk_reg("rst_ctrl", 32'h00, 32'h0);
        chk_reg("rst_presc", 32'h04, 32'h0);
        chk_reg("rst_count", 32'h08, 32'h0);
        chk_reg("rst_cmp", 32'h0C, 32'h0);
        chk_reg("rst_status", 32'h10, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d, off;
        int op;
        memwrite = 1'b0; memaddr = BASE; memwritedata = 32'h0;
        do_reset();

        // Reset in the middle of counting, then confirm the prescaler restarted.
        wr(32'h04, 32'd1);
        wr(32'h0C, 32'd100);
        wr(32'h00, 32'd1);
        idle(10);
        chk_reg("mid_count5", 32'h08, 32'd5);
        idle(1);
        do_reset();
        wr(32'h0C, 32'd100);
        wr(32'h00, 32'd1);
        idle(3);
        chk_reg("post_rst_pcnt", 32'h08, 32'd3);

        // Periodic: PRESC=3, CMP=4, AR=1 -> 20-cycle period.
        do_reset();
        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd4);
        wr(32'h00, 32'd3);
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) wr(32'h10, 32'd1);
            else idle(1);
            chk_reg("per_count", 32'h08, (k / 4) % 5);
            chk_reg("per_mf", 32'h10, ((k == 20) || (k == 40)) ? 32'd1 : 32'd0);
        end

        // One-shot.
        do_reset();
        wr(32'h0C, 32'd2);
        wr(32'h00, 32'd1);
        idle(1);
        chk_reg("os_c1", 32'h08, 32'd1);
        idle(1);
        chk_reg("os_c2", 32'h08, 32'd2);
        chk_reg("os_mf0", 32'h10, 32'd0);
        idle(1);
        chk_reg("os_mf1", 32'h10, 32'd1);
        chk_reg("os_hold", 32'h08, 32'd2);
        chk_reg("os_ctrl", 32'h00, 32'd0);
        idle(3);
        chk_reg("os_hold2", 32'h08, 32'd2);

        // Wrap and write/tick collision.
        do_reset();
        wr(32'h0C, 32'd7);
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h00, 32'd1);
        idle(1);
        chk_reg("wrap_count", 32'h08, 32'h0);
        chk_reg("wrap_mf", 32'h10, 32'h0);
        wr(32'h08, 32'h100);
        chk_reg("coll_count", 32'h08, 32'h100);
        idle(1);
        chk_reg("coll_next", 32'h08, 32'h101);

        // W1C race against a new match.
        do_reset();
        wr(32'h0C, 32'd1);
        wr(32'h00, 32'd3);
        idle(2);
        chk_reg("w1c_mf_set", 32'h10, 32'd1);
        idle(1);
        wr(32'h10, 32'd1);
        chk_reg("w1c_race", 32'h10, 32'd1);
        chk_reg("w1c_race_cnt", 32'h08, 32'd0);
        wr(32'h10, 32'd1);
        chk_reg("w1c_clear", 32'h10, 32'd0);

        // Decode.
        do_reset();
        memaddr = BASE + 32'h1C; #1; chk("hit_1c", {31'h0, hit}, 32'd1);
        memaddr = BASE + 32'h20; #1; chk("hit_20", {31'h0, hit}, 32'd0);
        memaddr = BASE - 32'h4;  #1; chk("hit_m4", {31'h0, hit}, 32'd0);
        wr(32'h20, 32'hFFFF_FFFF);
        wr(32'h28, 32'hFFFF_FFFF);
        wr(32'h14, 32'hFFFF_FFFF);
        chk_reg("dec_ctrl", 32'h00, 32'h0);
        chk_reg("dec_count", 32'h08, 32'h0);
        chk_reg("dec_rsvd", 32'h14, 32'h0);
        wr(32'h08, 32'h55);
        chk_reg("dec_nohit_rd", 32'h28, 32'h0);

        // Interrupt path.
        do_reset();
        wr(32'h0C, 32'd1);
        wr(32'h00, 32'd5);
        chk_reg("irq_ctrl", 32'h00, HAS_IRQ ? 32'd5 : 32'd1);
        idle(1);
        chk("irq_k1", {31'h0, irq}, 32'd0);
        idle(1);
        chk_reg("irq_mf", 32'h10, 32'd1);
        chk("irq_k2", {31'h0, irq}, 32'd0);
        idle(1);
        chk("irq_rise", {31'h0, irq}, {31'h0, HAS_IRQ});
        chk_reg("irq_ctrl2", 32'h00, HAS_IRQ ? 32'd4 : 32'd0);
        wr(32'h10, 32'd1);
        chk("irq_hold", {31'h0, irq}, {31'h0, HAS_IRQ});
        idle(1);
        chk("irq_fall", {31'h0, irq}, 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: wr(32'h00, ($urandom & 32'h7) | ($urandom_range(0, 3) != 0 ? 32'd1 : 32'd0));
                1: wr(32'h04, $urandom_range(0, 3));
                2: wr(32'h08, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : m_cmp - $urandom_range(0, 3));
                3: wr(32'h0C, $urandom_range(0, 5));
                4: wr(32'h10, $urandom);
                5: bus_cycle(1'b1, $urandom, $urandom);
                6: wr(32'h14 + 32'($urandom_range(0, 2)) * 32'd4, $urandom);
                default: idle(1);
            endcase
            chk_reg("rnd_ctrl", 32'h00, {29'h0, m_ie, m_ar, m_en});
            chk_reg("rnd_presc", 32'h04, {16'h0, m_presc});
            chk_reg("rnd_count", 32'h08, m_count);
            chk_reg("rnd_cmp", 32'h0C, m_cmp);
            chk_reg("rnd_status", 32'h10, {31'h0, m_mf});
            chk("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
            a = ($urandom_range(0, 1) == 1) ? BASE + $urandom_range(0, 63) : $urandom;
            off = a - BASE;
            memaddr = a; #1;
            chk("rnd_hit", {31'h0, hit}, (off < 32'd32) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
